uart_frame_checker: RTL and testbench

- Serial-line frame receiver/validator for 8N1-style UART frames, one bit per clock (no oversampling).
- Detects a start bit (0), shifts in DATA_BITS data bits LSB-first, then checks for a stop bit (1).
- Pulses `valid` for one cycle per correctly framed byte and presents the received byte.
- Sits directly behind the bit-rate-aligned serial input, ahead of any byte consumer.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_frame_checker.sv | 86 ++++++++
 tb/tb_uart_frame_checker.sv | 120 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg : shared types and defaults for the UART frame checker
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

   localparam int unsigned c_data_bits = 8;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      DATA = 3'd1,
      STOP = 3'd2,
      DONE = 3'd3,
      ERR  = 3'd4
   } uart_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_frame_checker.sv
// ---------------------------------------------------------------------------
// uart_frame_checker : one-bit-per-clock 8N1 frame receiver and stop-bit validator
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_frame_checker
   import uart_pkg::*;
#(
   parameter int unsigned DATA_BITS = c_data_bits
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 signal,
   output logic                 valid,
   output logic [DATA_BITS-1:0] data
);

   localparam int unsigned    c_cnt_w = $clog2(DATA_BITS) + 1;
   localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(DATA_BITS - 1);

   uart_state_t            r_state;
   logic [c_cnt_w-1:0]     r_cnt;
   logic [DATA_BITS-1:0]   r_shift;
   logic [DATA_BITS-1:0]   r_data;
   logic                   r_valid;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_shift <= '0;
         r_data  <= '0;
         r_valid <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (!signal) begin
                  r_state <= DATA;
                  r_cnt   <= '0;
               end
            end
            DATA: begin
               // Shifting in from the top leaves the first bit at the LSB after DATA_BITS shifts
               r_shift <= {signal, r_shift[DATA_BITS-1:1]};
               r_cnt   <= r_cnt + c_cnt_w'(1);
               if (r_cnt == c_last) begin
                  r_state <= STOP;
               end
            end
            STOP: begin
               if (signal) begin
                  r_state <= DONE;
                  r_data  <= r_shift;
                  r_valid <= 1'b1;
               end else begin
                  r_state <= ERR;
               end
            end
            DONE: begin
               if (!signal) begin
                  r_state <= DATA;
                  r_cnt   <= '0;
               end else begin
                  r_state <= IDLE;
               end
            end
            ERR: begin
               if (signal) begin
                  r_state <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign valid = r_valid;
   assign data  = r_data;

endmodule

`default_nettype wire

// File: tb/tb_uart_frame_checker.sv
// ---------------------------------------------------------------------------
// tb_uart_frame_checker : directed self-checking bench for uart_frame_checker
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_uart_frame_checker;

   logic       clk;
   logic       reset;
   logic       signal;
   logic       valid;
   logic [7:0] data;

   int checks = 0;
   int errors = 0;

   uart_frame_checker #(.DATA_BITS(8)) dut (
      .clk    (clk),
      .reset  (reset),
      .signal (signal),
      .valid  (valid),
      .data   (data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive one line bit, let one edge sample it, then check valid
   task automatic send_bit(input logic b, input logic exp_v, input string tag);
      signal = b;
      @(posedge clk);
      #1;
      chk(tag, {7'd0, valid}, {7'd0, exp_v});
   endtask

   // Start bit, eight data bits LSB-first, then the given stop bit
   task automatic send_frame(input logic [7:0] byte_v, input logic stop_b, input string tag);
      send_bit(1'b0, 1'b0, {tag, "_start"});
      for (int i = 0; i < 8; i++) begin
         send_bit(byte_v[i], 1'b0, {tag, "_data"});
      end
      send_bit(stop_b, stop_b, {tag, "_stop"});
   endtask

   initial begin
      reset  = 1'b0;
      signal = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_valid", {7'd0, valid}, 8'h00);
      chk("reset_data", data, 8'h00);
      reset = 1'b1;
      send_bit(1'b1, 1'b0, "idle0");

      // Good frame 0x55
      send_frame(8'h55, 1'b1, "f55");
      chk("f55_data", data, 8'h55);

      // Back-to-back frame with a bad stop bit
      send_frame(8'h56, 1'b0, "badstop");
      chk("badstop_data", data, 8'h55);

      // In ERR: a leading 0 must not start a frame
      send_bit(1'b0, 1'b0, "err_zero");
      for (int i = 0; i < 9; i++) begin
         send_bit(1'b1, 1'b0, "err_ones");
      end
      chk("err_data", data, 8'h55);

      // All-zero data
      send_frame(8'h00, 1'b1, "f00");
      chk("f00_data", data, 8'h00);
      send_bit(1'b1, 1'b0, "f00_after");

      // Good frame followed by a break
      send_frame(8'h55, 1'b1, "brk55");
      chk("brk55_data", data, 8'h55);
      send_bit(1'b0, 1'b0, "brk_start");
      for (int i = 0; i < 9; i++) begin
         send_bit(1'b0, 1'b0, "brk_low");
      end
      chk("brk_data", data, 8'h55);
      send_bit(1'b1, 1'b0, "brk_release");
      send_bit(1'b1, 1'b0, "brk_idle");

      // Reset in the middle of a frame
      send_bit(1'b0, 1'b0, "abort_start");
      send_bit(1'b1, 1'b0, "abort_d0");
      send_bit(1'b0, 1'b0, "abort_d1");
      send_bit(1'b1, 1'b0, "abort_d2");
      send_bit(1'b1, 1'b0, "abort_d3");
      reset = 1'b0;
      send_bit(1'b1, 1'b0, "abort_reset");
      chk("abort_data", data, 8'h00);
      reset = 1'b1;
      for (int i = 0; i < 5; i++) begin
         send_bit(1'b1, 1'b0, "abort_idle");
      end

      send_frame(8'hDB, 1'b1, "fdb");
      chk("fdb_data", data, 8'hDB);
      send_bit(1'b1, 1'b0, "fdb_one_cycle");
      chk("fdb_hold", data, 8'hDB);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
